// File: rtl/mul_uart_frame_ctrl.sv
// Frame sequencer between a UART rx/tx pair and an 8-bit multiplier.
// Accepts a SYNC,A,B request and answers with a 5A,P_hi,P_lo,CHK response.
module mul_uart_frame_ctrl #(
    parameter int TIMEOUT_CYC = 2500,
    parameter int MUL_LAT     = 2
) (
    input  logic        clk_int,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    input  logic [15:0] mul_p,
    output logic        busy,
    output logic [7:0]  err_cnt
);

    localparam logic [7:0] REQ_SYNC = 8'hA5;
    localparam logic [7:0] RSP_SYNC = 8'h5A;

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int LAT_W = $clog2(MUL_LAT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MUL_LAT - 1);

    typedef enum logic [2:0] {
        IDLE, GET_A, GET_B, CALC, LOAD, START, WAIT_BUSY, WAIT_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [LAT_W-1:0]  lat_cnt;
    logic [1:0]        idx;
    logic [15:0]       prod_q;

    logic ld_a, ld_b, cap_p, ld_tx, fire, idx_inc, tmo_run, err_inc;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    function automatic logic [7:0] rsp_byte(input logic [1:0] i, input logic [15:0] p);
        logic [7:0] b;
        case (i)
            2'd0:    b = RSP_SYNC;
            2'd1:    b = p[15:8];
            2'd2:    b = p[7:0];
            default: b = RSP_SYNC ^ p[15:8] ^ p[7:0];
        endcase
        return b;
    endfunction

    assign busy = (state_q != IDLE);

    always_ff @(posedge clk_int or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ld_a    = 1'b0;
        ld_b    = 1'b0;
        cap_p   = 1'b0;
        ld_tx   = 1'b0;
        fire    = 1'b0;
        idx_inc = 1'b0;
        tmo_run = 1'b0;
        err_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_valid && rx_data == REQ_SYNC) state_d = GET_A;
            end
            // A repeated sync byte here is data, not a resync.
            GET_A: begin
                if (rx_valid) begin
                    ld_a    = 1'b1;
                    state_d = GET_B;
                end else if (tmo_cnt == TMO_LAST) begin
                    err_inc = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_run = 1'b1;
                end
            end
            GET_B: begin
                if (rx_valid) begin
                    ld_b    = 1'b1;
                    state_d = CALC;
                end else if (tmo_cnt == TMO_LAST) begin
                    err_inc = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_run = 1'b1;
                end
            end
            CALC: begin
                if (lat_cnt == LAT_LAST) begin
                    cap_p   = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                ld_tx   = 1'b1;
                state_d = START;
            end
            START: begin
                if (tx_ready) begin
                    fire    = 1'b1;
                    state_d = WAIT_BUSY;
                end
            end
            // Wait for the transmitter to acknowledge by dropping ready, so a
            // stale ready level can never launch a second byte.
            WAIT_BUSY: begin
                if (!tx_ready) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_ready) begin
                    if (idx == 2'd3) begin
                        state_d = IDLE;
                    end else begin
                        idx_inc = 1'b1;
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (rx_valid && (state_q == CALC || state_q == LOAD ||
                         state_q == START || state_q == WAIT_BUSY ||
                         state_q == WAIT_DONE))
            err_inc = 1'b1;
    end

    always_ff @(posedge clk_int or posedge reset) begin
        if (reset) begin
            tx_data  <= 8'h00;
            tx_start <= 1'b0;
            mul_a    <= 8'h00;
            mul_b    <= 8'h00;
            err_cnt  <= 8'h00;
            tmo_cnt  <= '0;
            lat_cnt  <= '0;
            idx      <= 2'd0;
        end else begin
            tx_start <= fire;
            if (ld_a)  mul_a   <= rx_data;
            if (ld_b)  mul_b   <= rx_data;
            if (ld_tx) tx_data <= rsp_byte(idx, prod_q);
            if (cap_p)        idx <= 2'd0;
            else if (idx_inc) idx <= idx + 2'd1;
            if (tmo_run) tmo_cnt <= tmo_cnt + 1'b1;
            else         tmo_cnt <= '0;
            if (state_q == CALC && !cap_p) lat_cnt <= lat_cnt + 1'b1;
            else                           lat_cnt <= '0;
            if (err_inc) err_cnt <= sat_inc(err_cnt);
        end
    end

    // Product is pure data; it is always written before it is read.
    always_ff @(posedge clk_int) begin
        if (cap_p) prod_q <= mul_p;
    end

endmodule

// File: tb/tb_mul_uart_frame_ctrl.sv
// Directed bench for mul_uart_frame_ctrl with a 2-cycle multiplier model
// and a transmitter model that drops ready for a fixed time per byte.
module tb_mul_uart_frame_ctrl;

    localparam int TX_BUSY = 6;

    logic        clk_int;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic [15:0] mul_p;
    logic        busy;
    logic [7:0]  err_cnt;

    int          n_chk = 0;
    int          n_bad = 0;
    int          n_start = 0;
    int          n_start_bad = 0;
    logic        tx_hold = 1'b0;
    logic [15:0] mul_pipe = 16'h0;
    logic [7:0]  txq[$];
    int          err_exp = 0;

    mul_uart_frame_ctrl #(.TIMEOUT_CYC(2500), .MUL_LAT(2)) dut (
        .clk_int (clk_int),
        .reset   (reset),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_ready(tx_ready),
        .tx_data (tx_data),
        .tx_start(tx_start),
        .mul_a   (mul_a),
        .mul_b   (mul_b),
        .mul_p   (mul_p),
        .busy    (busy),
        .err_cnt (err_cnt)
    );

    initial begin
        clk_int = 1'b0;
        forever #5 clk_int = ~clk_int;
    end

    // Multiplier model: result visible at the second rising edge after the operands change.
    initial begin
        mul_p = 16'h0;
        forever begin
            @(negedge clk_int);
            mul_p    = mul_pipe;
            mul_pipe = 16'(mul_a) * 16'(mul_b);
        end
    end

    // Transmitter model: record each launched byte, then stay busy TX_BUSY cycles.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(negedge clk_int);
            if (tx_start) begin
                txq.push_back(tx_data);
                n_start++;
                tx_ready = 1'b0;
                for (int i = 0; i < TX_BUSY; i++) begin
                    @(negedge clk_int);
                    if (tx_start) n_start_bad++;
                end
            end
            tx_ready = !tx_hold;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk_int);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk_int);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_txn(input string tag, input int n, input int budget);
        int k = 0;
        while (txq.size() < n && k < budget) begin
            @(negedge clk_int);
            k++;
        end
        chk({tag, "_txcount"}, txq.size(), n);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk_int);
            k++;
        end
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic chk_rsp(input string tag, input logic [7:0] e1, input logic [7:0] e2,
                           input logic [7:0] e3);
        logic [7:0] exp_b[4];
        exp_b[0] = 8'h5A;
        exp_b[1] = e1;
        exp_b[2] = e2;
        exp_b[3] = e3;
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_b%0d", tag, i),
                (i < txq.size()) ? {24'h0, txq[i]} : 32'hDEAD, exp_b[i]);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] e1, input logic [7:0] e2,
                             input logic [7:0] e3, input bit extra);
        int s0;
        int k;
        txq.delete();
        s0 = n_start;
        send_byte(8'hA5);
        send_byte(a);
        send_byte(b);
        k = 0;
        while (k < 40) begin
            @(negedge clk_int);
            k++;
            if (tx_start) break;
        end
        chk({tag, "_latency"}, k, 5);
        if (extra) begin
            send_byte(8'h33);
            err_exp++;
        end
        wait_txn(tag, 4, 400);
        wait_idle(tag, 100);
        chk_rsp(tag, e1, e2, e3);
        chk({tag, "_mul_a"}, mul_a, a);
        chk({tag, "_mul_b"}, mul_b, b);
        chk({tag, "_err"}, err_cnt, err_exp);
        chk({tag, "_nstart"}, n_start - s0, 4);
        chk({tag, "_dblstart"}, n_start_bad, 0);
    endtask

    initial begin
        int s0;
        int k;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk_int);
        #1;
        chk("rst_tx_data", tx_data, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_mul_b", mul_b, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_cnt, 0);
        @(negedge clk_int);
        reset = 1'b0;

        run_frame("f37", 8'h03, 8'h07, 8'h00, 8'h15, 8'h4F, 1'b0);
        run_frame("fff", 8'hFF, 8'hFF, 8'hFE, 8'h01, 8'hA5, 1'b0);

        send_byte(8'h12);
        @(negedge clk_int);
        chk("junk_busy", busy, 0);
        run_frame("f22", 8'h02, 8'h02, 8'h00, 8'h04, 8'h5E, 1'b0);

        // Abandoned request: only one operand then silence.
        s0 = n_start;
        send_byte(8'hA5);
        send_byte(8'h10);
        k = 0;
        repeat (2490) begin
            @(negedge clk_int);
            k++;
        end
        chk("tmo_before_busy", busy, 1);
        repeat (110) @(negedge clk_int);
        err_exp++;
        chk("tmo_after_busy", busy, 0);
        chk("tmo_err", err_cnt, err_exp);
        chk("tmo_nstart", n_start - s0, 0);
        run_frame("f11", 8'h01, 8'h01, 8'h00, 8'h01, 8'h5B, 1'b0);

        run_frame("fovr", 8'h04, 8'h05, 8'h00, 8'h14, 8'h4E, 1'b1);

        // Transmitter held busy while bytes keep arriving.
        tx_hold = 1'b1;
        repeat (2) @(negedge clk_int);
        txq.delete();
        s0 = n_start;
        send_byte(8'hA5);
        send_byte(8'h06);
        send_byte(8'h07);
        repeat (10) @(negedge clk_int);
        chk("hold_busy", busy, 1);
        chk("hold_nstart", n_start - s0, 0);
        repeat (252) send_byte(8'h55);
        chk("sat_fe", err_cnt, 8'hFE);
        repeat (48) send_byte(8'h55);
        chk("sat_ff", err_cnt, 8'hFF);
        tx_hold = 1'b0;
        wait_txn("hold", 4, 400);
        wait_idle("hold", 100);
        chk_rsp("hold", 8'h00, 8'h2A, 8'h70);
        chk("hold_err", err_cnt, 8'hFF);

        // Reset while the third response byte is in flight.
        txq.delete();
        send_byte(8'hA5);
        send_byte(8'h08);
        send_byte(8'h09);
        wait_txn("rstmid", 3, 400);
        repeat (3) @(negedge clk_int);
        chk("rstmid_busy", busy, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("rstmid_tx_data", tx_data, 0);
        chk("rstmid_tx_start", tx_start, 0);
        chk("rstmid_mul_a", mul_a, 0);
        chk("rstmid_mul_b", mul_b, 0);
        chk("rstmid_busy0", busy, 0);
        chk("rstmid_err", err_cnt, 0);
        @(negedge clk_int);
        reset = 1'b0;
        s0 = n_start;
        repeat (100) @(negedge clk_int);
        chk("rstmid_nostart", n_start - s0, 0);
        chk("rstmid_idle", busy, 0);
        err_exp = 0;
        run_frame("f23", 8'h02, 8'h03, 8'h00, 8'h06, 8'h5C, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
